dreg_pipe: RTL and testbench

Parametrised elastic register pipeline, the clocked successor to the single-bit level-sensitive latch. It moves WIDTH-bit words through DEPTH edge-triggered stages with a valid/ready handshake, per-stage stall and an occupancy count. It sits between producer and consumer blocks that need fixed-latency retiming with backpressure.

---
 rtl/dreg_pkg.sv | 16 +
 rtl/dreg_stage.sv | 47 ++++
 rtl/dreg_pipe.sv | 95 +++++++++
 tb/tb_dreg_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dreg_pkg.sv
// Shared defaults and the counter-width helper for the dreg_pipe elastic register pipeline.
package dreg_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 3;

  // Ceiling log2 with a floor of 1 so the occupancy counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/dreg_stage.sv
// One elastic stage: valid bit plus data word, loaded whenever the downstream side is ready.
// With DREG_PIPE_FLUSH_EN defined, flush_i synchronously clears the valid bit.
module dreg_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef DREG_PIPE_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             rdy_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy_i) begin
      valid_d = valid_i;
      // Bubbles leave the previous word in place; only valid words overwrite data.
      if (valid_i) data_d = data_i;
    end
`ifdef DREG_PIPE_FLUSH_EN
    if (flush_i) valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dreg_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapse and occupancy count.
// Optional Flush port when DREG_PIPE_FLUSH_EN is defined.
module dreg_pipe
  import dreg_pkg::*;
#(
  parameter  int unsigned WIDTH = DefWidth,
  parameter  int unsigned DEPTH = DefDepth,
  localparam int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] D,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Q,
  output logic             Out_Valid,
  input  logic             Out_Ready,
`ifdef DREG_PIPE_FLUSH_EN
  input  logic             Flush,
`endif
  output logic [CW-1:0]    Count
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] v_in;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] d_in [DEPTH];

  // Unrolled form of rdy[i] = !v[i] | rdy[i+1]: ready if any stage at or after i is empty.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = Out_Ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v[j]) rdy[i] = 1'b1;
      end
    end
  end

  always_comb begin
    v_in[0] = In_Valid;
    d_in[0] = D;
    for (int i = 1; i < DEPTH; i++) begin
      v_in[i] = v[i-1];
      d_in[i] = d[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dreg_stage #(
      .Width(WIDTH)
    ) u_stage (
      .clk_i  (Clk),
      .rst_i  (Rst),
`ifdef DREG_PIPE_FLUSH_EN
      .flush_i(Flush),
`endif
      .rdy_i  (rdy[i]),
      .valid_i(v_in[i]),
      .data_i (d_in[i]),
      .valid_o(v[i]),
      .data_o (d[i])
    );
  end

  assign In_Ready  = rdy[0];
  assign Q         = d[DEPTH-1];
  assign Out_Valid = v[DEPTH-1];

  logic          xfer_in, xfer_out;
  logic [CW-1:0] count_d, count_q;

  always_comb begin
    xfer_in  = In_Valid & rdy[0];
    xfer_out = v[DEPTH-1] & Out_Ready;
    count_d  = count_q;
    if (xfer_in && !xfer_out) begin
      count_d = count_q + CW'(1);
    end else if (!xfer_in && xfer_out) begin
      count_d = count_q - CW'(1);
    end
`ifdef DREG_PIPE_FLUSH_EN
    if (Flush) count_d = '0;
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign Count = count_q;

endmodule

// File: tb/tb_dreg_pipe.sv
// Self-checking bench for dreg_pipe (WIDTH=8, DEPTH=3) with a negedge scoreboard monitor.
// Define DREG_PIPE_FLUSH_EN to also exercise the Flush port.
module tb_dreg_pipe;

  localparam int unsigned W   = 8;
  localparam int unsigned DEP = 3;
  localparam int unsigned CWT = $clog2(DEP + 1);

  logic           Clk;
  logic           Rst;
  logic [W-1:0]   D;
  logic           In_Valid;
  logic           In_Ready;
  logic [W-1:0]   Q;
  logic           Out_Valid;
  logic           Out_Ready;
  logic [CWT-1:0] Count;
`ifdef DREG_PIPE_FLUSH_EN
  logic           Flush;
`endif

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q [$];
  int           mcnt   = 0;
  bit           mon_en = 0;

  dreg_pipe #(
    .WIDTH(W),
    .DEPTH(DEP)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .D        (D),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Q        (Q),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
`ifdef DREG_PIPE_FLUSH_EN
    .Flush    (Flush),
`endif
    .Count    (Count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Scoreboard: handshakes seen mid-cycle are the transfers taken at the next rising edge.
  always @(negedge Clk) begin
    if (mon_en && !Rst) begin
      logic [W-1:0] e;
      logic         exp_rdy;
      checks++;
      if (Count !== CWT'(mcnt)) begin
        errors++;
        $display("FAIL sb_count: got %0d required %0d at %0t", Count, mcnt, $time);
      end
      exp_rdy = (mcnt < int'(DEP)) || Out_Ready;
      checks++;
      if (In_Ready !== exp_rdy) begin
        errors++;
        $display("FAIL sb_in_ready: got %b required %b at %0t", In_Ready, exp_rdy, $time);
      end
      if (mcnt == 0) begin
        checks++;
        if (Out_Valid !== 1'b0) begin
          errors++;
          $display("FAIL sb_empty_valid: got %b required 0 at %0t", Out_Valid, $time);
        end
      end
      if (In_Valid && In_Ready) begin
        exp_q.push_back(D);
        mcnt++;
      end
      if (Out_Valid && Out_Ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_order: got %h required no word at %0t", Q, $time);
        end else begin
          e = exp_q.pop_front();
          if (Q !== e) begin
            errors++;
            $display("FAIL sb_order: got %h required %h at %0t", Q, e, $time);
          end
        end
        mcnt--;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    repeat (DEP + 2) tick();
  endtask

  task automatic test_reset();
    Rst       = 1'b0;
    D         = '0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
`ifdef DREG_PIPE_FLUSH_EN
    Flush     = 1'b0;
`endif
    #1 Rst = 1'b1;
    #1;
    checks++;
    if (Q !== '0 || Out_Valid !== 1'b0 || Count !== '0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: got Q=%h ov=%b cnt=%0d ir=%b required 00 0 0 1",
               Q, Out_Valid, Count, In_Ready);
    end
    In_Valid = 1'b1;
    D        = 8'hFF;
    tick();
    checks++;
    if (Count !== '0 || Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: got cnt=%0d ov=%b ir=%b required 0 0 1", Count, Out_Valid,
               In_Ready);
    end
    In_Valid = 1'b0;
    Rst      = 1'b0;
    mon_en   = 1'b1;
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals    [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int unsigned  exp_cnt [7] = '{1, 2, 3, 3, 2, 1, 0};
    Out_Ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) begin
        In_Valid = 1'b1;
        D        = vals[k-1];
      end else begin
        In_Valid = 1'b0;
        D        = '0;
      end
      tick();
      checks++;
      if (Count !== CWT'(exp_cnt[k-1])) begin
        errors++;
        $display("FAIL stream_count edge %0d: got %0d required %0d", k, Count, exp_cnt[k-1]);
      end
      checks++;
      if (k >= 3 && k <= 6) begin
        if (Out_Valid !== 1'b1 || Q !== vals[k-3]) begin
          errors++;
          $display("FAIL stream_q edge %0d: got ov=%b Q=%h required 1 %h", k, Out_Valid, Q,
                   vals[k-3]);
        end
      end else if (Out_Valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_valid edge %0d: got %b required 0", k, Out_Valid);
      end
    end
  endtask

  task automatic test_fill_stall();
    Out_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      In_Valid = 1'b1;
      D        = 8'hA1 + W'(k);
      tick();
    end
    D = 8'hA4;
    #1;
    checks++;
    if (In_Ready !== 1'b0 || Count !== CWT'(3) || Q !== 8'hA1 || Out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got ir=%b cnt=%0d Q=%h ov=%b required 0 3 a1 1", In_Ready,
               Count, Q, Out_Valid);
    end
    tick();
    checks++;
    if (Count !== CWT'(3) || Q !== 8'hA1) begin
      errors++;
      $display("FAIL fill_hold: got cnt=%0d Q=%h required 3 a1", Count, Q);
    end
    Out_Ready = 1'b1;
    #1;
    checks++;
    if (In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_release_ready: got %b required 1", In_Ready);
    end
    tick();
    checks++;
    if (Count !== CWT'(3) || Q !== 8'hA2) begin
      errors++;
      $display("FAIL fill_inout: got cnt=%0d Q=%h required 3 a2", Count, Q);
    end
    drain();
    checks++;
    if (Count !== '0) begin
      errors++;
      $display("FAIL fill_drain: got %0d required 0", Count);
    end
  endtask

  task automatic test_bubble();
    Out_Ready = 1'b0;
    In_Valid  = 1'b1;
    D         = 8'h01;
    tick();
    In_Valid = 1'b0;
    repeat (2) tick();
    In_Valid = 1'b1;
    D        = 8'h02;
    tick();
    In_Valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (Count !== CWT'(2) || Q !== 8'h01 || Out_Valid !== 1'b1 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL bubble_pack: got cnt=%0d Q=%h ov=%b ir=%b required 2 01 1 1", Count, Q,
               Out_Valid, In_Ready);
    end
    In_Valid = 1'b1;
    D        = 8'h03;
    tick();
    In_Valid = 1'b0;
    checks++;
    if (Count !== CWT'(3) || In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL bubble_full: got cnt=%0d ir=%b required 3 0", Count, In_Ready);
    end
    drain();
  endtask

  task automatic test_count_random();
    for (int k = 0; k < 20; k++) begin
      In_Valid  = (k % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      D         = W'($urandom);
      Out_Ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    checks++;
    if (Count !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got cnt=%0d pending=%0d required 0 0", Count, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    Out_Ready = 1'b0;
    In_Valid  = 1'b1;
    D         = 8'hC3;
    tick();
    In_Valid = 1'b0;
    tick();
    In_Valid = 1'b1;
    D        = 8'hC4;
    tick();
    In_Valid = 1'b0;
    checks++;
    if (Q !== 8'hC3 || Count !== CWT'(2)) begin
      errors++;
      $display("FAIL midreset_pre: got Q=%h cnt=%0d required c3 2", Q, Count);
    end
    #2;
    mon_en = 1'b0;
    Rst    = 1'b1;
    #1;
    checks++;
    if (Q !== '0 || Out_Valid !== 1'b0 || Count !== '0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: got Q=%h ov=%b cnt=%0d ir=%b required 00 0 0 1", Q,
               Out_Valid, Count, In_Ready);
    end
    tick();
    Rst = 1'b0;
    exp_q.delete();
    mcnt   = 0;
    mon_en = 1'b1;
    Out_Ready = 1'b1;
    repeat (DEP + 1) tick();
    checks++;
    if (Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard: got ov=%b required 0", Out_Valid);
    end
  endtask

`ifdef DREG_PIPE_FLUSH_EN
  task automatic test_flush();
    Out_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      In_Valid = 1'b1;
      D        = 8'hB1 + W'(k);
      tick();
    end
    mon_en    = 1'b0;
    Flush     = 1'b1;
    In_Valid  = 1'b1;
    D         = 8'h55;
    Out_Ready = 1'b1;
    tick();
    checks++;
    if (Out_Valid !== 1'b0 || Count !== '0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got ov=%b cnt=%0d ir=%b required 0 0 1", Out_Valid, Count,
               In_Ready);
    end
    Flush    = 1'b0;
    In_Valid = 1'b0;
    exp_q.delete();
    mcnt   = 0;
    mon_en = 1'b1;
    for (int k = 0; k < DEP + 2; k++) begin
      tick();
      checks++;
      if (Out_Valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_drop: got ov=%b Q=%h required no output", Out_Valid, Q);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    Out_Ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      In_Valid = 1'b1;
      D        = 8'h60 + W'(k);
      tick();
    end
    drain();
    checks++;
    if (Count !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got cnt=%0d pending=%0d required 0 0", Count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_stall();
    test_bubble();
    test_count_random();
    test_reset_midstream();
`ifdef DREG_PIPE_FLUSH_EN
    test_flush();
`endif
    test_back_to_back();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
